// File: rtl/axis_hdr_arb_pkg.sv
// Shared constants, FSM state encodings and the round-robin pick helper
// for the header-insert arbiter.
package axis_hdr_arb_pkg;

  localparam int MAX_CH = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  // Returns the index of the first set request at or after ptr (wrapping), or -1.
  function automatic int rr_pick(input logic [MAX_CH-1:0] req, input int ptr, input int n_ch);
    int win;
    int cand;
    win = -1;
    for (int off = MAX_CH - 1; off >= 0; off--) begin
      if (off < n_ch) begin
        cand = ptr + off;
        if (cand >= n_ch) cand = cand - n_ch;
        if (req[cand[4:0]]) win = cand;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/axis_hdr_insert_arbiter_rr.sv
// Combinational round-robin arbiter: request vector + pointer -> one-hot winner.
module axis_rr_arbiter
  import axis_hdr_arb_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CH_WD = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [CH_WD-1:0] rr_ptr,
  output logic [N_CH-1:0]  gnt
);

  logic [MAX_CH-1:0] req_ext;
  int                win;

  always_comb begin
    req_ext = '0;
    req_ext[N_CH-1:0] = req;
    win = rr_pick(req_ext, int'(rr_ptr), N_CH);
    gnt = '0;
    for (int i = 0; i < N_CH; i++) gnt[i] = (win == i);
  end

endmodule

// File: rtl/axis_hdr_insert_arbiter.sv
// Per-packet round-robin arbiter feeding a shared header-insert block.
// Optional payload-stall watchdog enabled by defining AXIS_HDR_ARB_WDOG_EN.
//
// state   | meaning
// IDLE    | no grant; picks next requester when any header is valid
// HDR     | granted channel's header routed to the insert port
// DATA    | granted channel's payload routed until the last beat
module axis_hdr_insert_arbiter
  import axis_hdr_arb_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
  parameter int N_CH         = 4,
  parameter int CH_WD        = $clog2(N_CH)
`ifdef AXIS_HDR_ARB_WDOG_EN
  , parameter int WDOG_CYC   = 1024
`endif
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_CH-1:0]               s_hdr_valid,
  input  logic [N_CH*DATA_WD-1:0]       s_hdr_data,
  input  logic [N_CH*DATA_BYTE_WD-1:0]  s_hdr_keep,
  input  logic [N_CH*BYTE_CNT_WD-1:0]   s_hdr_cnt,
  output logic [N_CH-1:0]               s_hdr_ready,
  input  logic [N_CH-1:0]               s_valid,
  input  logic [N_CH-1:0]               s_last,
  input  logic [N_CH*DATA_WD-1:0]       s_data,
  input  logic [N_CH*DATA_BYTE_WD-1:0]  s_keep,
  output logic [N_CH-1:0]               s_ready,
  output logic                          m_ins_valid,
  output logic [DATA_WD-1:0]            m_ins_data,
  output logic [DATA_BYTE_WD-1:0]       m_ins_keep,
  output logic [BYTE_CNT_WD-1:0]        m_ins_cnt,
  input  logic                          m_ins_ready,
  output logic                          m_valid,
  output logic [DATA_WD-1:0]            m_data,
  output logic [DATA_BYTE_WD-1:0]       m_keep,
  output logic                          m_last,
  input  logic                          m_ready,
  output logic [N_CH-1:0]               grant,
  output logic                          busy
`ifdef AXIS_HDR_ARB_WDOG_EN
  , output logic                        wdog_err
`endif
);

  logic [1:0]       state;
  logic [CH_WD-1:0] g_idx;
  logic [CH_WD-1:0] rr_ptr;
  logic [CH_WD-1:0] next_ptr;
  logic [CH_WD-1:0] arb_idx;
  logic [N_CH-1:0]  arb_gnt;
  logic             ins_hs;
  logic             beat_hs;
  logic             wdog_fire;

  axis_rr_arbiter #(.N_CH(N_CH), .CH_WD(CH_WD)) u_rr (
    .req    (s_hdr_valid),
    .rr_ptr (rr_ptr),
    .gnt    (arb_gnt)
  );

  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < N_CH; i++)
      if (arb_gnt[i]) arb_idx = CH_WD'(i);
  end

  assign ins_hs   = m_ins_valid & m_ins_ready;
  assign beat_hs  = m_valid & m_ready;
  assign next_ptr = (g_idx == CH_WD'(N_CH - 1)) ? '0 : g_idx + 1'b1;
  assign busy     = (state != ST_IDLE);

  // Outputs are forced to zero outside the active phase so idle data never leaks.
  always_comb begin
    m_ins_valid = 1'b0;
    m_ins_data  = '0;
    m_ins_keep  = '0;
    m_ins_cnt   = '0;
    m_valid     = 1'b0;
    m_data      = '0;
    m_keep      = '0;
    m_last      = 1'b0;
    s_hdr_ready = '0;
    s_ready     = '0;
    if (state == ST_HDR) begin
      m_ins_valid        = s_hdr_valid[g_idx];
      m_ins_data         = s_hdr_data[g_idx*DATA_WD +: DATA_WD];
      m_ins_keep         = s_hdr_keep[g_idx*DATA_BYTE_WD +: DATA_BYTE_WD];
      m_ins_cnt          = s_hdr_cnt[g_idx*BYTE_CNT_WD +: BYTE_CNT_WD];
      s_hdr_ready[g_idx] = m_ins_ready;
    end else if (state == ST_DATA) begin
      m_valid        = s_valid[g_idx];
      m_data         = s_data[g_idx*DATA_WD +: DATA_WD];
      m_keep         = s_keep[g_idx*DATA_BYTE_WD +: DATA_BYTE_WD];
      m_last         = s_last[g_idx];
      s_ready[g_idx] = m_ready;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      grant  <= '0;
      g_idx  <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        ST_IDLE: if (|s_hdr_valid) begin
          grant <= arb_gnt;
          g_idx <= arb_idx;
          state <= ST_HDR;
        end
        ST_HDR: if (ins_hs) state <= ST_DATA;
        ST_DATA: if ((beat_hs && m_last) || wdog_fire) begin
          state  <= ST_IDLE;
          grant  <= '0;
          rr_ptr <= next_ptr;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef AXIS_HDR_ARB_WDOG_EN
  localparam int WDOG_WD = $clog2(WDOG_CYC + 1);
  logic [WDOG_WD-1:0] wdog_cnt;

  // Down-counter reloads on every beat; terminal count with no beat aborts the packet.
  assign wdog_fire = (state == ST_DATA) && !beat_hs && (wdog_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt <= WDOG_WD'(WDOG_CYC - 1);
      wdog_err <= 1'b0;
    end else begin
      wdog_err <= wdog_fire;
      if (state != ST_DATA || beat_hs) wdog_cnt <= WDOG_WD'(WDOG_CYC - 1);
      else if (wdog_cnt != '0)         wdog_cnt <= wdog_cnt - 1'b1;
    end
  end
`else
  assign wdog_fire = 1'b0;
`endif

endmodule

// File: tb/tb_axis_hdr_insert_arbiter.sv
// Self-checking bench for axis_hdr_insert_arbiter; scoreboard of headers and beats.
module tb_axis_hdr_insert_arbiter;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int CW = 2;
  localparam int N  = 4;
`ifdef AXIS_HDR_ARB_WDOG_EN
  localparam int WC = 16;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0]    s_hdr_valid, s_hdr_ready, s_valid, s_last, s_ready, grant;
  logic [N*DW-1:0] s_hdr_data, s_data;
  logic [N*BW-1:0] s_hdr_keep, s_keep;
  logic [N*CW-1:0] s_hdr_cnt;
  logic            m_ins_valid, m_ins_ready, m_valid, m_ready, m_last, busy;
  logic [DW-1:0]   m_ins_data, m_data;
  logic [BW-1:0]   m_ins_keep, m_keep;
  logic [CW-1:0]   m_ins_cnt;
`ifdef AXIS_HDR_ARB_WDOG_EN
  logic            wdog_err;
`endif

  always #5 clk = ~clk;

  axis_hdr_insert_arbiter #(
    .DATA_WD(DW), .N_CH(N)
`ifdef AXIS_HDR_ARB_WDOG_EN
    , .WDOG_CYC(WC)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_hdr_valid(s_hdr_valid), .s_hdr_data(s_hdr_data), .s_hdr_keep(s_hdr_keep),
    .s_hdr_cnt(s_hdr_cnt), .s_hdr_ready(s_hdr_ready),
    .s_valid(s_valid), .s_last(s_last), .s_data(s_data), .s_keep(s_keep), .s_ready(s_ready),
    .m_ins_valid(m_ins_valid), .m_ins_data(m_ins_data), .m_ins_keep(m_ins_keep),
    .m_ins_cnt(m_ins_cnt), .m_ins_ready(m_ins_ready),
    .m_valid(m_valid), .m_data(m_data), .m_keep(m_keep), .m_last(m_last), .m_ready(m_ready),
    .grant(grant), .busy(busy)
`ifdef AXIS_HDR_ARB_WDOG_EN
    , .wdog_err(wdog_err)
`endif
  );

  typedef struct packed { logic [DW-1:0] d; logic [BW-1:0] k; logic [CW-1:0] c; } hdr_t;
  typedef struct packed { logic [DW-1:0] d; logic [BW-1:0] k; logic l; } beat_t;
  hdr_t  exp_hdr[$];
  beat_t exp_beat[$];
  int errors = 0;
  int checks = 0;

  function automatic logic [DW-1:0] hword(input int ch, input int pkt);
    return 32'hA000_0000 + 32'(ch) * 32'h0001_0000 + 32'(pkt);
  endfunction
  function automatic logic [DW-1:0] bword(input int ch, input int pkt, input int b);
    return 32'hB000_0000 + 32'(ch) * 32'h0001_0000 + 32'(pkt) * 32'h100 + 32'(b);
  endfunction
  function automatic logic [BW-1:0] hkeep(input int ch);
    return BW'(4'hF >> ch);
  endfunction
  function automatic logic [CW-1:0] hcnt(input int ch);
    return CW'(ch + 1);
  endfunction

  task automatic load_hdr(input int ch, input int pkt);
    s_hdr_data[ch*DW +: DW] = hword(ch, pkt);
    s_hdr_keep[ch*BW +: BW] = hkeep(ch);
    s_hdr_cnt[ch*CW +: CW]  = hcnt(ch);
  endtask
  task automatic load_beat(input int ch, input int pkt, input int b, input int nb);
    s_data[ch*DW +: DW] = bword(ch, pkt, b);
    s_keep[ch*BW +: BW] = (b == nb - 1) ? 4'h7 : 4'hF;
    s_last[ch]          = (b == nb - 1);
  endtask
  task automatic push_hdr(input int ch, input int pkt);
    exp_hdr.push_back('{d: hword(ch, pkt), k: hkeep(ch), c: hcnt(ch)});
  endtask
  task automatic push_beat(input int ch, input int pkt, input int b, input int nb);
    exp_beat.push_back('{d: bword(ch, pkt, b), k: (b == nb - 1) ? 4'h7 : 4'hF, l: (b == nb - 1)});
  endtask

  // Every negedge passes through here: leak check plus scoreboard pops on handshakes.
  task automatic sample();
    hdr_t  gh, eh;
    beat_t gb, eb;
    @(negedge clk);
    checks++;
    if ((((s_hdr_ready | s_ready) & ~grant) != '0) || ($countones(grant) > 1)) begin
      errors++;
      $display("FAIL ready_leak grant=%b s_hdr_ready=%b s_ready=%b", grant, s_hdr_ready, s_ready);
    end
    if (m_ins_valid && m_ins_ready) begin
      checks++;
      gh = '{d: m_ins_data, k: m_ins_keep, c: m_ins_cnt};
      if (exp_hdr.size() == 0) begin
        errors++; $display("FAIL hdr_sb unexpected header got=%h", gh);
      end else begin
        eh = exp_hdr.pop_front();
        if (gh !== eh) begin errors++; $display("FAIL hdr_sb got=%h exp=%h", gh, eh); end
      end
    end
    if (m_valid && m_ready) begin
      checks++;
      gb = '{d: m_data, k: m_keep, l: m_last};
      if (exp_beat.size() == 0) begin
        errors++; $display("FAIL beat_sb unexpected beat got=%h", gb);
      end else begin
        eb = exp_beat.pop_front();
        if (gb !== eb) begin errors++; $display("FAIL beat_sb got=%h exp=%h", gb, eb); end
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_on();
    rst_n = 1'b0;
    s_hdr_valid = '0; s_valid = '0; s_last = '0;
    s_hdr_data = '0; s_hdr_keep = '0; s_hdr_cnt = '0; s_data = '0; s_keep = '0;
    m_ins_ready = 1'b0; m_ready = 1'b0;
    exp_hdr.delete(); exp_beat.delete();
    sample(); adv(); sample(); adv();
  endtask

  task automatic wait_grant(input logic [N-1:0] exp, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sample();
      if (grant === exp) begin ok = 1'b1; break; end
      adv();
    end
  endtask

  // Drives one packet on ch; returns just after the last beat's accepting edge.
  task automatic send_pkt(input int ch, input int pkt, input int nb, input int hdr_stall, input bit toggle);
    bit ok;
    bit hs;
    int b;
    load_hdr(ch, pkt); s_hdr_valid[ch] = 1'b1;
    load_beat(ch, pkt, 0, nb); s_valid[ch] = 1'b1;
    push_hdr(ch, pkt);
    for (int i = 0; i < nb; i++) push_beat(ch, pkt, i, nb);
    m_ins_ready = (hdr_stall == 0);
    m_ready = 1'b1;
    wait_grant(N'(1) << ch, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL grant_timeout ch=%0d grant=%b", ch, grant); return; end
    for (int k = 0; k < hdr_stall; k++) begin
      checks++;
      if (s_hdr_ready[ch] !== 1'b0 || s_ready !== '0 || m_valid !== 1'b0 || m_ins_valid !== 1'b1) begin
        errors++;
        $display("FAIL hdr_stall cyc=%0d s_hdr_ready=%b s_ready=%b m_valid=%b m_ins_valid=%b exp 0/0/0/1",
                 k, s_hdr_ready, s_ready, m_valid, m_ins_valid);
      end
      adv();
      if (k == hdr_stall - 1) m_ins_ready = 1'b1;
      sample();
    end
    checks++;
    if (s_hdr_ready[ch] !== 1'b1) begin errors++; $display("FAIL hdr_ready got=%b exp=1", s_hdr_ready[ch]); end
    adv();
    s_hdr_valid[ch] = 1'b0;
    b = 0;
    for (int cyc = 0; cyc < 64 && b < nb; cyc++) begin
      if (toggle) m_ready = cyc[0];
      sample();
      checks++;
      if (m_ins_valid !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL data_phase m_ins_valid=%b busy=%b exp 0/1", m_ins_valid, busy);
      end
      hs = m_valid && m_ready;
      adv();
      if (hs) begin
        b++;
        if (b < nb) load_beat(ch, pkt, b, nb);
        else begin s_valid[ch] = 1'b0; s_last[ch] = 1'b0; end
      end
    end
    checks++;
    if (b != nb) begin errors++; $display("FAIL beat_timeout got=%0d exp=%0d", b, nb); end
  endtask

  task automatic test_reset();
    reset_on();
    s_hdr_valid = '1; s_valid = '1; s_last = '1;
    for (int c = 0; c < N; c++) begin load_hdr(c, 7); load_beat(c, 7, 0, 1); end
    m_ins_ready = 1'b1; m_ready = 1'b1;
    sample();
    checks++;
    if (grant !== '0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_state grant=%b busy=%b exp 0/0", grant, busy);
    end
    checks++;
    if (m_ins_valid !== 1'b0 || m_valid !== 1'b0 || m_last !== 1'b0) begin
      errors++; $display("FAIL reset_valid m_ins_valid=%b m_valid=%b m_last=%b exp 0", m_ins_valid, m_valid, m_last);
    end
    checks++;
    if (s_hdr_ready !== '0 || s_ready !== '0) begin
      errors++; $display("FAIL reset_ready s_hdr_ready=%b s_ready=%b exp 0", s_hdr_ready, s_ready);
    end
    checks++;
    if (m_ins_data !== '0 || m_data !== '0 || m_ins_keep !== '0 || m_keep !== '0 || m_ins_cnt !== '0) begin
      errors++; $display("FAIL reset_data m_ins_data=%h m_data=%h exp 0", m_ins_data, m_data);
    end
    adv();
  endtask

  task automatic test_single();
    reset_on();
    rst_n = 1'b1;
    send_pkt(1, 0, 3, 0, 1'b0);
    sample();
    checks++;
    if (grant !== '0 || busy !== 1'b0) begin
      errors++; $display("FAIL single_end grant=%b busy=%b exp 0/0", grant, busy);
    end
    checks++;
    if (exp_hdr.size() != 0 || exp_beat.size() != 0) begin
      errors++; $display("FAIL single_left hdr=%0d beats=%0d exp 0/0", exp_hdr.size(), exp_beat.size());
    end
    m_ins_ready = 1'b0;
    adv();
    load_hdr(1, 1); load_hdr(2, 1);
    s_hdr_valid = 4'b0110;
    sample(); adv(); sample();
    checks++;
    if (grant !== 4'b0100) begin errors++; $display("FAIL rr_ptr_after_ch1 grant=%b exp=0100", grant); end
    adv();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp;
    reset_on();
    for (int c = 0; c < N; c++) begin load_hdr(c, 0); load_beat(c, 0, 0, 1); end
    s_hdr_valid = '1; s_valid = '1;
    m_ins_ready = 1'b1; m_ready = 1'b1;
    for (int p = 0; p < 5; p++) begin push_hdr(p % N, 0); push_beat(p % N, 0, 0, 1); end
    rst_n = 1'b1;
    for (int t = 0; t < 15; t++) begin
      sample();
      exp = (t % 3 == 0) ? '0 : N'(1) << ((t / 3) % N);
      checks++;
      if (grant !== exp) begin errors++; $display("FAIL rr_seq t=%0d grant=%b exp=%b", t, grant, exp); end
      adv();
    end
    s_hdr_valid = '0; s_valid = '0;
    sample();
    checks++;
    if (exp_hdr.size() != 0 || exp_beat.size() != 0) begin
      errors++; $display("FAIL rr_left hdr=%0d beats=%0d exp 0/0", exp_hdr.size(), exp_beat.size());
    end
    adv();
  endtask

  task automatic test_hdr_stall();
    reset_on();
    rst_n = 1'b1;
    send_pkt(3, 2, 2, 5, 1'b0);
    sample();
    checks++;
    if (busy !== 1'b0 || exp_beat.size() != 0) begin
      errors++; $display("FAIL stall_end busy=%b beats_left=%0d exp 0/0", busy, exp_beat.size());
    end
    adv();
  endtask

  task automatic test_ready_toggle();
    reset_on();
    rst_n = 1'b1;
    s_valid = 4'b1110;
    for (int c = 1; c < N; c++) load_beat(c, 9, 0, 2);
    send_pkt(0, 3, 4, 0, 1'b1);
    sample();
    checks++;
    if (exp_beat.size() != 0 || grant !== '0) begin
      errors++; $display("FAIL toggle_end beats_left=%0d grant=%b exp 0/0", exp_beat.size(), grant);
    end
    adv();
  endtask

  task automatic test_reset_mid();
    bit ok;
    reset_on();
    rst_n = 1'b1;
    load_hdr(2, 4); load_beat(2, 4, 0, 3);
    s_hdr_valid[2] = 1'b1; s_valid[2] = 1'b1;
    push_hdr(2, 4);
    m_ins_ready = 1'b1; m_ready = 1'b0;
    wait_grant(4'b0100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL mid_grant_timeout grant=%b exp=0100", grant); end
    adv();
    s_hdr_valid[2] = 1'b0;
    sample();
    checks++;
    if (busy !== 1'b1 || m_valid !== 1'b1) begin
      errors++; $display("FAIL mid_data busy=%b m_valid=%b exp 1/1", busy, m_valid);
    end
    adv();
    rst_n = 1'b0;
    load_hdr(0, 5);
    s_hdr_valid = 4'b0101;
    m_ins_ready = 1'b0;
    sample();
    checks++;
    if (grant !== '0 || busy !== 1'b0 || m_valid !== 1'b0 || m_ins_valid !== 1'b0) begin
      errors++; $display("FAIL mid_reset grant=%b busy=%b m_valid=%b m_ins_valid=%b exp 0",
                         grant, busy, m_valid, m_ins_valid);
    end
    adv();
    rst_n = 1'b1;
    sample(); adv(); sample();
    checks++;
    if (grant !== 4'b0001) begin errors++; $display("FAIL after_reset grant=%b exp=0001", grant); end
    adv();
  endtask

`ifdef AXIS_HDR_ARB_WDOG_EN
  task automatic test_wdog();
    bit ok;
    bit seen;
    int n;
    reset_on();
    rst_n = 1'b1;
    load_hdr(1, 0); s_hdr_valid[1] = 1'b1;
    push_hdr(1, 0);
    m_ins_ready = 1'b1; m_ready = 1'b1;
    wait_grant(4'b0010, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL wdog_grant_timeout grant=%b exp=0010", grant); end
    adv();
    s_hdr_valid[1] = 1'b0; m_ins_ready = 1'b0;
    load_hdr(0, 1); load_hdr(2, 1);
    s_hdr_valid = 4'b0101;
    seen = 1'b0; n = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      sample();
      if (wdog_err === 1'b1) begin seen = 1'b1; n = i; end
      else adv();
    end
    checks++;
    if (n != WC + 1) begin errors++; $display("FAIL wdog_latency got=%0d exp=%0d", n, WC + 1); end
    checks++;
    if (grant !== '0 || busy !== 1'b0) begin
      errors++; $display("FAIL wdog_idle grant=%b busy=%b exp 0/0", grant, busy);
    end
    adv();
    sample();
    checks++;
    if (wdog_err !== 1'b0 || grant !== 4'b0100) begin
      errors++; $display("FAIL wdog_next wdog_err=%b grant=%b exp 0/0100", wdog_err, grant);
    end
    adv();
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_hdr_stall();
    test_ready_toggle();
    test_reset_mid();
`ifdef AXIS_HDR_ARB_WDOG_EN
    test_wdog();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
